// File: rtl/nrs_pkg.sv
// Shared constants and state encoding for the NRS c_init sequencer.
package nrs_pkg;

    localparam logic [2:0] NRS_SYM0    = 3'd5;
    localparam logic [2:0] NRS_SYM1    = 3'd6;
    localparam int         N_SLOTS     = 20;
    localparam int         RUNS_PER_SF = 4;
    localparam logic [3:0] MAX_SF_IDX  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_WAIT   = 2'd3
    } nrs_state_e;

endpackage

// File: rtl/nrs_cinit_calc.sv
// Combinational c_init = 2^10*(7*(n_s+1)+l+1)*(2*N_ID+1) + 2*N_ID + 1.
module nrs_cinit_calc #(
    parameter int CELL_ID_W = 9,
    parameter int CINIT_W   = 31
) (
    input  logic [4:0]           slot,
    input  logic [2:0]           sym,
    input  logic [CELL_ID_W-1:0] cell_id,
    output logic [CINIT_W-1:0]   cinit
);

    logic [CINIT_W-1:0] sym_term;
    logic [CINIT_W-1:0] cell_term;

    // Largest result stays below 2^28, so the full-width product never wraps.
    always_comb begin
        sym_term  = CINIT_W'(7) * (CINIT_W'(slot) + CINIT_W'(1)) + CINIT_W'(sym) + CINIT_W'(1);
        cell_term = (CINIT_W'(cell_id) << 1) + CINIT_W'(1);
        cinit     = ((sym_term * cell_term) << 10) + cell_term;
    end

endmodule

// File: rtl/nrs_seq_ctrl.sv
// Issues four c_init launches per NRS subframe to the Gold generator.
// state  | meaning
// IDLE   | waiting for sf_start of an NRS-bearing subframe
// CALC   | registering c_init for the current (slot, sym)
// LAUNCH | offering cinit until gold_ready
// WAIT   | Gold run in progress, waiting for gold_done
module nrs_seq_ctrl
    import nrs_pkg::*;
#(
    parameter int CELL_ID_W = 9,
    parameter int CINIT_W   = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sf_start,
    input  logic [3:0]           sf_idx,
    input  logic                 sf_has_nrs,
    input  logic [CELL_ID_W-1:0] cell_id,
    input  logic                 gold_ready,
    input  logic                 gold_done,
    output logic [CINIT_W-1:0]   cinit,
    output logic                 cinit_valid,
    output logic [4:0]           slot,
    output logic [2:0]           sym,
    output logic                 last_run,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [1:0] LAST_RUN = 2'(RUNS_PER_SF - 1);

    nrs_state_e           state, state_nxt;
    logic [CELL_ID_W-1:0] cell_id_q;
    logic [4:0]           slot_q;
    logic [2:0]           sym_q;
    logic [1:0]           run_cnt;
    logic [CINIT_W-1:0]   cinit_q;
    logic [CINIT_W-1:0]   cinit_calc;
    logic                 overrun_q;
    logic                 accept;
    logic                 advance;

    nrs_cinit_calc #(
        .CELL_ID_W (CELL_ID_W),
        .CINIT_W   (CINIT_W)
    ) u_cinit_calc (
        .slot    (slot_q),
        .sym     (sym_q),
        .cell_id (cell_id_q),
        .cinit   (cinit_calc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sf_start && sf_has_nrs && (sf_idx <= MAX_SF_IDX)) begin
                    accept    = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC:   state_nxt = ST_LAUNCH;
            ST_LAUNCH: if (gold_ready) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (gold_done) begin
                    if (run_cnt == LAST_RUN) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_CALC;
                    end
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        cinit_valid = (state == ST_LAUNCH);
        last_run    = busy && (run_cnt == LAST_RUN);
    end

    // Run order within a subframe: (2s,5), (2s,6), (2s+1,5), (2s+1,6).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cell_id_q <= '0;
            slot_q    <= '0;
            sym_q     <= '0;
            run_cnt   <= '0;
            cinit_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= sf_start && ((state != ST_IDLE) || (sf_idx > MAX_SF_IDX));
            if (accept) begin
                cell_id_q <= cell_id;
                slot_q    <= {sf_idx, 1'b0};
                sym_q     <= NRS_SYM0;
                run_cnt   <= '0;
            end
            if (state == ST_CALC) cinit_q <= cinit_calc;
            if (advance) begin
                run_cnt <= run_cnt + 2'd1;
                if (sym_q == NRS_SYM0) begin
                    sym_q <= NRS_SYM1;
                end else begin
                    sym_q  <= NRS_SYM0;
                    slot_q <= slot_q + 5'd1;
                end
            end
        end
    end

    assign cinit   = cinit_q;
    assign slot    = slot_q;
    assign sym     = sym_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_nrs_seq_ctrl.sv
// Directed bench for nrs_seq_ctrl: runs whole subframes against a hand-driven Gold generator.
module tb_nrs_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sf_start = 1'b0;
    logic [3:0]  sf_idx = '0;
    logic        sf_has_nrs = 1'b0;
    logic [8:0]  cell_id = '0;
    logic        gold_ready = 1'b0;
    logic        gold_done = 1'b0;
    logic [30:0] cinit;
    logic        cinit_valid;
    logic [4:0]  slot;
    logic [2:0]  sym;
    logic        last_run;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nrs_seq_ctrl #(.CELL_ID_W(9), .CINIT_W(31)) dut (
        .clk         (clk),
        .rst         (rst),
        .sf_start    (sf_start),
        .sf_idx      (sf_idx),
        .sf_has_nrs  (sf_has_nrs),
        .cell_id     (cell_id),
        .gold_ready  (gold_ready),
        .gold_done   (gold_done),
        .cinit       (cinit),
        .cinit_valid (cinit_valid),
        .slot        (slot),
        .sym         (sym),
        .last_run    (last_run),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_sf(input logic [8:0] cid, input logic [3:0] sfi);
        sf_start = 1'b1; sf_idx = sfi; sf_has_nrs = 1'b1; cell_id = cid;
        @(negedge clk);
        sf_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || cinit_valid !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL start_calc busy=%0b valid=%0b overrun=%0b required 1 0 0", busy, cinit_valid, overrun);
            errors++;
        end
    endtask

    task automatic serve_run(input logic [30:0] ec, input logic [4:0] es, input logic [2:0] ey,
                             input bit is_last, input int hold, input bit tied, input bit inject);
        int n = 0;
        while (cinit_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cinit_valid !== 1'b1) begin
            $display("FAIL launch_timeout valid=%0b required 1", cinit_valid);
            errors++;
            return;
        end
        checks++;
        if (n != 1) begin
            $display("FAIL launch_latency cycles=%0d required 1", n);
            errors++;
        end
        checks++;
        if (cinit !== ec || slot !== es || sym !== ey || last_run !== is_last) begin
            $display("FAIL run_values cinit=%0d slot=%0d sym=%0d last=%0b required %0d %0d %0d %0b",
                     cinit, slot, sym, last_run, ec, es, ey, is_last);
            errors++;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (cinit_valid !== 1'b1 || cinit !== ec) begin
                $display("FAIL stall_stable cycle=%0d valid=%0b cinit=%0d required 1 %0d", i, cinit_valid, cinit, ec);
                errors++;
            end
        end
        gold_ready = 1'b1;
        @(negedge clk);
        if (!tied) gold_ready = 1'b0;
        checks++;
        if (cinit_valid !== 1'b0) begin
            $display("FAIL handshake_drop valid=%0b required 0", cinit_valid);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            if (inject && i == 0) begin
                sf_start = 1'b1; sf_idx = 4'd3; sf_has_nrs = 1'b1;
            end
            @(negedge clk);
            if (inject && i == 0) begin
                sf_start = 1'b0;
                checks++;
                if (overrun !== 1'b1) begin
                    $display("FAIL overrun_pulse overrun=%0b required 1", overrun);
                    errors++;
                end
            end
            if (inject && i == 1) begin
                checks++;
                if (overrun !== 1'b0) begin
                    $display("FAIL overrun_width overrun=%0b required 0", overrun);
                    errors++;
                end
            end
            checks++;
            if (cinit_valid !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL wait_state valid=%0b busy=%0b required 0 1", cinit_valid, busy);
                errors++;
            end
        end
        gold_done = 1'b1;
        @(negedge clk);
        gold_done = 1'b0;
        checks++;
        if (busy !== !is_last || cinit_valid !== 1'b0) begin
            $display("FAIL after_done busy=%0b valid=%0b required %0b 0", busy, cinit_valid, !is_last);
            errors++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (cinit !== '0 || cinit_valid !== 1'b0 || slot !== '0 || sym !== '0 ||
            last_run !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL reset_values cinit=%0d valid=%0b slot=%0d sym=%0d last=%0b busy=%0b ovr=%0b required all 0",
                     cinit, cinit_valid, slot, sym, last_run, busy, overrun);
            errors++;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        gold_ready = 1'b1;
        start_sf(9'd0, 4'd0);
        serve_run(31'd13313, 5'd0, 3'd5, 1'b0, 0, 1'b1, 1'b0);
        serve_run(31'd14337, 5'd0, 3'd6, 1'b0, 0, 1'b1, 1'b0);
        serve_run(31'd20481, 5'd1, 3'd5, 1'b0, 0, 1'b1, 1'b0);
        serve_run(31'd21505, 5'd1, 3'd6, 1'b1, 0, 1'b1, 1'b0);
        gold_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || last_run !== 1'b0 || cinit_valid !== 1'b0) begin
            $display("FAIL basic_idle busy=%0b last=%0b valid=%0b required 0 0 0", busy, last_run, cinit_valid);
            errors++;
        end
    endtask

    task automatic test_max_cell();
        start_sf(9'd503, 4'd9);
        serve_run(31'd143333359, 5'd18, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd144364527, 5'd18, 3'd6, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd150551535, 5'd19, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd151582703, 5'd19, 3'd6, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_stall();
        start_sf(9'd1, 4'd0);
        serve_run(31'd39939, 5'd0, 3'd5, 1'b0, 10, 1'b0, 1'b0);
        serve_run(31'd43011, 5'd0, 3'd6, 1'b0, 3, 1'b0, 1'b0);
        serve_run(31'd61443, 5'd1, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd64515, 5'd1, 3'd6, 1'b1, 10, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        start_sf(9'd2, 4'd1);
        serve_run(31'd138245, 5'd2, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd143365, 5'd2, 3'd6, 1'b0, 0, 1'b0, 1'b1);
        serve_run(31'd174085, 5'd3, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd179205, 5'd3, 3'd6, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_no_nrs_and_bad_idx();
        sf_start = 1'b1; sf_idx = 4'd2; sf_has_nrs = 1'b0; cell_id = 9'd7;
        @(negedge clk);
        sf_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cinit_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || slot !== 5'd3 || sym !== 3'd6) begin
                $display("FAIL no_nrs cycle=%0d valid=%0b busy=%0b ovr=%0b slot=%0d sym=%0d required 0 0 0 3 6",
                         i, cinit_valid, busy, overrun, slot, sym);
                errors++;
            end
            @(negedge clk);
        end
        sf_start = 1'b1; sf_idx = 4'd12; sf_has_nrs = 1'b1;
        @(negedge clk);
        sf_start = 1'b0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL bad_idx overrun=%0b busy=%0b required 1 0", overrun, busy);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (overrun !== 1'b0 || cinit_valid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL bad_idx_after cycle=%0d ovr=%0b valid=%0b busy=%0b required 0 0 0",
                         i, overrun, cinit_valid, busy);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        start_sf(9'd0, 4'd5);
        while (cinit_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        gold_ready = 1'b1;
        @(negedge clk);
        gold_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cinit !== '0 || cinit_valid !== 1'b0 || slot !== '0 || sym !== '0 ||
            last_run !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL async_reset cinit=%0d valid=%0b slot=%0d sym=%0d last=%0b busy=%0b ovr=%0b required all 0",
                     cinit, cinit_valid, slot, sym, last_run, busy, overrun);
            errors++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_sf(9'd0, 4'd1);
        serve_run(31'd27649, 5'd2, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd28673, 5'd2, 3'd6, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd34817, 5'd3, 3'd5, 1'b0, 0, 1'b0, 1'b0);
        serve_run(31'd35841, 5'd3, 3'd6, 1'b1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_cell();
        test_stall();
        test_start_while_busy();
        test_no_nrs_and_bad_idx();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrs_seq_ctrl.md
# nrs_seq_ctrl

Sequencer for the NRS value generator. For each NRS-bearing subframe it issues four c_init launches to the Gold-sequence generator, one per NRS OFDM symbol (slot 2·sf, l=5,6; slot 2·sf+1, l=5,6), and waits for each run to finish. It sits between subframe timing (upstream) and the Gold generator / NRS mapper (downstream). It owns the slot/symbol bookkeeping and c_init arithmetic.

## Interface
- CELL_ID_W, 9, width of cell_id (N_ID^cell, 0..503)
- CINIT_W, 31, width of cinit
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- sf_start  in  1  one-cycle pulse at subframe start
- sf_idx  in  4  subframe index 0..9, sampled with sf_start
- sf_has_nrs  in  1  subframe carries NRS, sampled with sf_start
- cell_id  in  9  physical cell ID, sampled with sf_start
- gold_ready  in  1  Gold generator accepts cinit this cycle
- gold_done  in  1  one-cycle pulse: current run finished
- cinit  out  31  c_init for current run
- cinit_valid  out  1  cinit offered to Gold generator
- slot  out  5  n_s of current run (0..19)
- sym  out  3  l of current run (5 or 6)
- last_run  out  1  high during the 4th run of the subframe
- busy  out  1  high in any state other than IDLE
- overrun  out  1  one-cycle pulse: sf_start or sf_idx error rejected

## Operation
- FSM states: IDLE, CALC, LAUNCH, WAIT.
- IDLE: on sf_start with sf_has_nrs=1 and sf_idx≤9 -> latch cell_id, slot=2·sf_idx, sym=5, run_cnt=0 -> CALC. With sf_has_nrs=0 -> stay IDLE, no outputs change. With sf_idx>9 -> overrun pulse, stay IDLE.
- CALC: register cinit = 1024·(7·(slot+1)+sym+1)·(2·cell_id+1) + 2·cell_id + 1, then -> LAUNCH. Max value 151582703 (<2^28); no truncation; upper bits zero.
- LAUNCH: cinit_valid=1, cinit stable. When gold_ready=1 -> WAIT; cinit_valid drops next cycle.
- WAIT: on gold_done: if run_cnt=3 -> IDLE; else advance (sym 5->6; sym 6->5 with slot+1), run_cnt+1 -> CALC.
- run order fixed: (2s,5),(2s,6),(2s+1,5),(2s+1,6).
- last_run = (run_cnt==3) in CALC/LAUNCH/WAIT.
- sf_start while busy: ignored, overrun pulse, current sequence continues unchanged.
- gold_done outside WAIT: ignored.
- gold_ready and gold_done meaningful only in LAUNCH and WAIT respectively; simultaneous arrival in other states has no effect.

## Timing
- Reset: state IDLE, cinit=0, cinit_valid=0, slot=0, sym=0, last_run=0, busy=0, overrun=0, run_cnt=0.
- sf_start at cycle T -> CALC at T+1 -> cinit_valid=1 at T+2.
- Handshake transfer in cycle where cinit_valid & gold_ready; gold_ready may already be high on entry (zero wait).
- gold_done at cycle D -> next cinit_valid at D+2.
- Minimum subframe turnaround: 4×(2 + generator latency) + handshake cycles.
- overrun: registered, high exactly one cycle after offending sf_start.
- Reset mid-run: all outputs return to reset values immediately; no partial run resumes.

## Structure
- Shared package/header nrs_pkg: NRS_SYM0=5, NRS_SYM1=6, N_SLOTS=20, RUNS_PER_SF=4, MAX_SF_IDX=9, FSM state encoding.
- Sub-module nrs_cinit_calc: c_init arithmetic from slot, sym, cell_id (combinational; registered in parent CALC state).

## Test plan
- cell_id=0, sf_idx=0, gold_ready tied 1, gold_done 5 cycles after each accept -> cinit 13313, 14337, 20481, 21505; slot 0,0,1,1; last_run only on 4th; busy drops after 4th gold_done.
- cell_id=503, sf_idx=9 -> 4th run slot=19, sym=6, cinit=151582703.
- gold_ready held 0 for 10 cycles in LAUNCH -> cinit_valid and cinit stay stable for all 10 cycles; single transfer on release.
- sf_start during WAIT -> overrun pulse one cycle later; remaining runs still complete with the original slot values.
- sf_has_nrs=0, then sf_idx=12 -> no cinit_valid; overrun only for sf_idx=12.
- rst asserted in WAIT -> all outputs 0 asynchronously; next sf_start starts cleanly at run 0.
